spi_xfer_arbiter: RTL
=====================

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 Parameter DATA_W, 32: word width of requester data and SPI FIFO data.
REQ-002 Parameter TAG_DEPTH, 8: maximum outstanding transfers (power of two, 2..16).
REQ-003 Port clk, in, 1: sole clock, the Avalon-side clock domain of both SPI FIFOs.
REQ-004 Port reset_n, in, 1: asynchronous, active-low reset.
REQ-005 Ports reqN_valid (in, 1), reqN_data (in, DATA_W), reqN_ready (out, 1), N=0,1: transmit-word request handshake per requester.
REQ-006 Ports rspN_valid (out, 1), rspN_data (out, DATA_W), rspN_ready (in, 1), N=0,1: received-word response handshake per requester.
REQ-007 Ports wr_fifo_wrreq (out, 1), wr_fifo_data (out, DATA_W), wr_fifo_full (in, 1): write-FIFO push side.
REQ-008 Ports rd_fifo_rdreq (out, 1), rd_fifo_q (in, DATA_W), rd_fifo_empty (in, 1): read-FIFO pop side; q is valid the cycle after rdreq.
REQ-009 Ports outstanding (out, $clog2(TAG_DEPTH)+1), err_orphan (out, 1), orphan_cnt (out, 8): status.

Function
REQ-010 A transfer issues in a cycle when the granted reqN_valid=1, wr_fifo_full=0 and tag count < TAG_DEPTH; issue asserts wr_fifo_wrreq with wr_fifo_data=reqN_data in the same cycle, combinationally.
REQ-011 reqN_ready is 1 only in the cycle requester N issues; at most one issue per cycle.
REQ-012 Arbitration is round-robin: with both valid, grant goes to the requester not granted last; with one valid, it is granted; last_grant updates only on issue; reset value of last_grant is 1 (requester 0 wins first tie).
REQ-013 Each issue pushes the requester ID into the tag queue; push is blocked at count==TAG_DEPTH even if a pop occurs the same cycle.
REQ-014 Return FSM states: RET_IDLE, RET_WAIT, RET_HOLD, RET_DRAIN.
REQ-015 RET_IDLE: when rd_fifo_empty=0 and tag count>0, assert rd_fifo_rdreq for one cycle and go to RET_WAIT; when rd_fifo_empty=0 and tag count==0, assert rd_fifo_rdreq and go to RET_DRAIN.
REQ-016 RET_WAIT: capture rd_fifo_q into the response register, pop the head tag, go to RET_HOLD.
REQ-017 RET_HOLD: rspT_valid=1 for popped tag T with rspT_data=captured word; the other rspN_valid=0; on rspT_ready=1 go to RET_IDLE.
REQ-018 RET_DRAIN: discard rd_fifo_q, set err_orphan (sticky), increment orphan_cnt saturating at 255, return to RET_IDLE.
REQ-019 Latency: rd_fifo_empty falling in RET_IDLE to rspT_valid is exactly 2 cycles; minimum response throughput is one word per 3 cycles.
REQ-020 outstanding equals tag queue count; simultaneous push and pop leave it unchanged.
REQ-021 Responses return strictly in issue order, regardless of requester.
REQ-022 rd_fifo_rdreq never asserts outside RET_IDLE; wr_fifo_wrreq never asserts while wr_fifo_full=1.

Reset
REQ-023 On reset_n=0, asynchronously: FSM=RET_IDLE, tag queue empty, outstanding=0, all reqN_ready, rspN_valid, wr_fifo_wrreq, rd_fifo_rdreq =0, rspN_data=0, err_orphan=0, orphan_cnt=0, last_grant=1.
REQ-024 Reset mid-transfer discards in-flight tags and any held response; FIFO contents are cleared by the same reset externally.

Structure
REQ-025 Package spi_arb_pkg holds DATA_W and TAG_DEPTH defaults and the return FSM state enum.
REQ-026 Tag queue is sub-module spi_tag_fifo (1-bit entries, TAG_DEPTH deep, count output, synchronous push/pop, asynchronous reset).

Verification
REQ-027 req0 alone sends 0xA5A5_0001, loopback returns it -> wr_fifo_wrreq 1 cycle, rsp0_valid 2 cycles after rd_fifo_empty falls, rsp0_data=0xA5A5_0001.
REQ-028 req0 and req1 both valid continuously, 4 issues -> grant order 0,1,0,1; responses routed rsp0,rsp1,rsp0,rsp1 in that order.
REQ-029 No responses returned, req0 valid for 10 cycles -> exactly 8 issues, outstanding=8, req0_ready=0 thereafter.
REQ-030 wr_fifo_full=1 for 5 cycles with req1 valid -> no wrreq, req1_ready=0; issue on the first cycle full=0.
REQ-031 rd_fifo_empty=0 with outstanding=0 -> one rdreq, no rspN_valid, err_orphan=1, orphan_cnt=1; 300 orphans -> orphan_cnt=255.
REQ-032 reset_n low while in RET_HOLD with rsp1_valid=1 -> rsp1_valid=0 immediately, outstanding=0, FSM RET_IDLE after release.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared defaults, the return-path FSM state type and the
// round-robin pick helper for the SPI transfer arbiter.
package spi_arb_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int TAG_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    RET_IDLE  = 2'd0,
    RET_WAIT  = 2'd1,
    RET_HOLD  = 2'd2,
    RET_DRAIN = 2'd3
  } ret_state_e;

  // Two-way round-robin pick: on a tie the requester that did not win last
  // time is chosen; a lone requester always wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    logic g;
    if (v0 && v1) begin
      g = ~last;
    end else if (v1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/spi_tag_fifo.sv
// spi_tag_fifo: DEPTH-deep queue of 1-bit requester tags recording the
// order in which transfers were issued.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, din         enqueue a tag (ignored when full, even if popping)
//   pop               dequeue the head tag (ignored when empty)
//   dout              current head tag
//   count             number of stored tags (0..DEPTH)
//   full              count == DEPTH
module spi_tag_fifo
  import spi_arb_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic [AW:0]   count,
  output logic          full
);

  logic [DEPTH-1:0] mem_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Push is gated on the registered full flag only, so a pop in the same
  // cycle never frees room for a push.
  always_comb begin
    full      = (count_r == (AW+1)'(DEPTH));
    do_push_s = push && !full;
    do_pop_s  = pop && (count_r != (AW+1)'(0));
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_r    <= '0;
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one SPI write/read FIFO pair between two
// requesters. Transmit words are issued round-robin into the write FIFO;
// each received word is routed back to the requester whose transfer is
// oldest, so responses return in issue order.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid/data/ready        transmit-word request handshake (N=0,1)
//   rspN_valid/data/ready        received-word response handshake (N=0,1)
//   wr_fifo_wrreq/data/full      write-FIFO push side
//   rd_fifo_rdreq/q/empty        read-FIFO pop side (q valid cycle after rdreq)
//   outstanding                  transfers issued but not yet answered
//   err_orphan, orphan_cnt       sticky flag / saturating count of words
//                                received with no transfer outstanding
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF,
  localparam int CW       = $clog2(TAG_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic              wr_fifo_wrreq,
  output logic [DATA_W-1:0] wr_fifo_data,
  input  logic              wr_fifo_full,
  output logic              rd_fifo_rdreq,
  input  logic [DATA_W-1:0] rd_fifo_q,
  input  logic              rd_fifo_empty,
  output logic [CW-1:0]     outstanding,
  output logic              err_orphan,
  output logic [7:0]        orphan_cnt
);

  ret_state_e        state_r;
  ret_state_e        state_nxt;
  logic              last_grant_r;
  logic              grant_s;
  logic              issue_s;
  logic              rdreq_s;
  logic              tag_head_s;
  logic              tag_full_s;
  logic              tag_pop_s;
  logic [CW-1:0]     tag_count_s;
  logic              rsp_tag_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              err_orphan_r;
  logic [7:0]        orphan_cnt_r;
  logic              rsp_ack_s;

  // Issue decision; gated by reset_n so nothing handshakes while in reset.
  always_comb begin
    grant_s = rr_pick(req0_valid, req1_valid, last_grant_r);
    if (reset_n && !wr_fifo_full && !tag_full_s && (req0_valid || req1_valid)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign req0_ready    = issue_s && !grant_s;
  assign req1_ready    = issue_s && grant_s;
  assign wr_fifo_wrreq = issue_s;
  assign wr_fifo_data  = grant_s ? req1_data : req0_data;

  // Round-robin history: moves only when a transfer actually issues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
    end else if (issue_s) begin
      last_grant_r <= grant_s;
    end
  end

  assign tag_pop_s = (state_r == RET_WAIT);

  spi_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (issue_s),
    .din     (grant_s),
    .pop     (tag_pop_s),
    .dout    (tag_head_s),
    .count   (tag_count_s),
    .full    (tag_full_s)
  );

  assign outstanding = tag_count_s;

  // Handshake of the requester currently being answered.
  always_comb begin
    if (rsp_tag_r) begin
      rsp_ack_s = rsp1_ready;
    end else begin
      rsp_ack_s = rsp0_ready;
    end
  end

  // Return FSM next-state and read-FIFO pop request.
  always_comb begin
    state_nxt = state_r;
    rdreq_s   = 1'b0;
    case (state_r)
      RET_IDLE: begin
        if (!rd_fifo_empty) begin
          rdreq_s = 1'b1;
          if (tag_count_s != CW'(0)) begin
            state_nxt = RET_WAIT;
          end else begin
            state_nxt = RET_DRAIN;
          end
        end else begin
          state_nxt = RET_IDLE;
        end
      end
      RET_WAIT:  state_nxt = RET_HOLD;
      RET_HOLD: begin
        if (rsp_ack_s) begin
          state_nxt = RET_IDLE;
        end else begin
          state_nxt = RET_HOLD;
        end
      end
      RET_DRAIN: state_nxt = RET_IDLE;
      default:   state_nxt = RET_IDLE;
    endcase
  end

  assign rd_fifo_rdreq = rdreq_s && reset_n;

  // Return FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RET_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Response capture: word and its owning tag are latched together in
  // RET_WAIT, the cycle in which rd_fifo_q carries the requested word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_r <= '0;
      rsp_tag_r  <= 1'b0;
    end else if (state_r == RET_WAIT) begin
      rsp_data_r <= rd_fifo_q;
      rsp_tag_r  <= tag_head_s;
    end
  end

  assign rsp0_valid = (state_r == RET_HOLD) && !rsp_tag_r;
  assign rsp1_valid = (state_r == RET_HOLD) && rsp_tag_r;
  assign rsp0_data  = rsp_data_r;
  assign rsp1_data  = rsp_data_r;

  // Orphan bookkeeping: sticky flag and saturating counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_orphan_r <= 1'b0;
      orphan_cnt_r <= 8'd0;
    end else if (state_r == RET_DRAIN) begin
      err_orphan_r <= 1'b1;
      if (orphan_cnt_r != 8'hFF) begin
        orphan_cnt_r <= orphan_cnt_r + 8'd1;
      end
    end
  end

  assign err_orphan = err_orphan_r;
  assign orphan_cnt = orphan_cnt_r;

endmodule
